vector_alu_seq: RTL

- Multi-lane, handshaked successor to the single-cycle scalar ALU, used in the vector execute stage.
- Applies one opcode to all LANES lanes at once.
- Move, add, subtract and pass complete in one cycle; multiply and divide are iterative and take WIDTH cycles.
- Results and per-lane NZCV flags are registered and held until the consumer accepts them.

---
 rtl/vector_alu_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/vector_alu_seq.sv
// Multi-lane handshaked ALU: one opcode applied to all lanes. MOV/ADD/SUB/PASS
// finish at the accept edge; MUL/DIV iterate one bit per cycle for WIDTH cycles.
module vector_alu_seq #(
    parameter int WIDTH = 19,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             op,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [LANES-1:0]       flag_n,
    output logic [LANES-1:0]       flag_z,
    output logic [LANES-1:0]       flag_c,
    output logic [LANES-1:0]       flag_v
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [3:0] OP_MOV = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_is_mul;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_a [LANES];
    logic [WIDTH-1:0]       r_b [LANES];
    // MUL: {partial product high, remaining multiplier bits}; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]     r_acc [LANES];
    logic [LANES*WIDTH-1:0] r_result;
    logic [LANES-1:0]       r_n;
    logic [LANES-1:0]       r_z;
    logic [LANES-1:0]       r_c;
    logic [LANES-1:0]       r_v;

    logic                   w_accept;
    logic                   w_is_iter;
    logic                   w_last;
    logic                   w_load;
    logic [WIDTH:0]         w_sum [LANES];
    logic [WIDTH:0]         w_mul_sum [LANES];
    logic [WIDTH:0]         w_rem_sh [LANES];
    logic                   w_div_ge [LANES];
    logic [WIDTH-1:0]       w_rem_new [LANES];
    logic [2*WIDTH-1:0]     w_acc_next [LANES];
    logic [WIDTH-1:0]       w_lane_res [LANES];
    logic [LANES*WIDTH-1:0] w_res_next;
    logic [LANES-1:0]       w_c_next;
    logic [LANES-1:0]       w_v_next;

    // Handshake decode and next-state selection.
    always_comb begin
        w_accept     = in_valid && (r_state == ST_IDLE);
        w_is_iter    = (op == OP_MUL) || (op == OP_DIV);
        w_last       = (r_state == ST_BUSY) && (r_cnt == {CW{1'b0}});
        w_load       = (w_accept && !w_is_iter) || w_last;
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_iter ? ST_BUSY : ST_DONE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Per-lane datapath: single-cycle ops from live inputs, one MUL/DIV step from captured operands.
    always_comb begin
        w_res_next = {(LANES*WIDTH){1'b0}};
        w_c_next   = {LANES{1'b0}};
        w_v_next   = {LANES{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            w_mul_sum[l] = {1'b0, r_acc[l][2*WIDTH-1:WIDTH]}
                         + (r_acc[l][0] ? {1'b0, r_a[l]} : {(WIDTH+1){1'b0}});
            w_rem_sh[l]  = r_acc[l][2*WIDTH-1:WIDTH-1];
            w_div_ge[l]  = (w_rem_sh[l] >= {1'b0, r_b[l]});
            w_rem_new[l] = w_div_ge[l] ? (w_rem_sh[l][WIDTH-1:0] - r_b[l]) : w_rem_sh[l][WIDTH-1:0];
            if (r_is_mul) begin
                w_acc_next[l] = {w_mul_sum[l], r_acc[l][WIDTH-1:1]};
            end else begin
                w_acc_next[l] = {w_rem_new[l], r_acc[l][WIDTH-2:0], w_div_ge[l]};
            end
            w_sum[l]      = {(WIDTH+1){1'b0}};
            w_lane_res[l] = a[l*WIDTH +: WIDTH];
            if (r_state == ST_BUSY) begin
                w_lane_res[l] = w_acc_next[l][WIDTH-1:0];
                if (r_is_mul) begin
                    w_c_next[l] = |w_acc_next[l][2*WIDTH-1:WIDTH];
                    w_v_next[l] = |w_acc_next[l][2*WIDTH-1:WIDTH];
                end else begin
                    w_c_next[l] = 1'b0;
                    w_v_next[l] = (r_b[l] == {WIDTH{1'b0}});
                end
            end else begin
                case (op)
                    OP_MOV: w_lane_res[l] = b[l*WIDTH +: WIDTH];
                    OP_ADD: begin
                        w_sum[l]      = {1'b0, a[l*WIDTH +: WIDTH]} + {1'b0, b[l*WIDTH +: WIDTH]};
                        w_lane_res[l] = w_sum[l][WIDTH-1:0];
                        w_c_next[l]   = w_sum[l][WIDTH];
                        w_v_next[l]   = (a[l*WIDTH+WIDTH-1] == b[l*WIDTH+WIDTH-1])
                                     && (w_sum[l][WIDTH-1] != a[l*WIDTH+WIDTH-1]);
                    end
                    OP_SUB: begin
                        w_sum[l]      = {1'b0, a[l*WIDTH +: WIDTH]} + {1'b0, ~b[l*WIDTH +: WIDTH]}
                                      + {{WIDTH{1'b0}}, 1'b1};
                        w_lane_res[l] = w_sum[l][WIDTH-1:0];
                        w_c_next[l]   = w_sum[l][WIDTH];
                        w_v_next[l]   = (a[l*WIDTH+WIDTH-1] != b[l*WIDTH+WIDTH-1])
                                     && (w_sum[l][WIDTH-1] != a[l*WIDTH+WIDTH-1]);
                    end
                    default: w_lane_res[l] = a[l*WIDTH +: WIDTH];
                endcase
            end
            w_res_next[l*WIDTH +: WIDTH] = w_lane_res[l];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture and iteration counter for MUL/DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_mul <= 1'b0;
            r_cnt    <= {CW{1'b0}};
            for (int l = 0; l < LANES; l++) begin
                r_a[l]   <= {WIDTH{1'b0}};
                r_b[l]   <= {WIDTH{1'b0}};
                r_acc[l] <= {(2*WIDTH){1'b0}};
            end
        end else if (w_accept && w_is_iter) begin
            r_is_mul <= (op == OP_MUL);
            r_cnt    <= CNT_LOAD;
            for (int l = 0; l < LANES; l++) begin
                r_a[l]   <= a[l*WIDTH +: WIDTH];
                r_b[l]   <= b[l*WIDTH +: WIDTH];
                r_acc[l] <= {{WIDTH{1'b0}}, (op == OP_MUL) ? b[l*WIDTH +: WIDTH] : a[l*WIDTH +: WIDTH]};
            end
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            for (int l = 0; l < LANES; l++) begin
                r_acc[l] <= w_acc_next[l];
            end
        end
    end

    // Result and flag registers, held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= {(LANES*WIDTH){1'b0}};
            r_n      <= {LANES{1'b0}};
            r_z      <= {LANES{1'b0}};
            r_c      <= {LANES{1'b0}};
            r_v      <= {LANES{1'b0}};
        end else if (w_load) begin
            r_result <= w_res_next;
            r_c      <= w_c_next;
            r_v      <= w_v_next;
            for (int l = 0; l < LANES; l++) begin
                r_n[l] <= w_res_next[l*WIDTH+WIDTH-1];
                r_z[l] <= (w_res_next[l*WIDTH +: WIDTH] == {WIDTH{1'b0}});
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign flag_n    = r_n;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_v    = r_v;

endmodule
